// File: rtl/fir_pkg.sv
// fir_pkg: shared mode encoding and accumulator sizing for fir_filter
package fir_pkg;
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} mode_e;
    function automatic int acc_width(int data_w, int coef_w, int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction
endpackage

// File: rtl/fir_filter_if.sv
// fir_filter_if: sample stream, coefficient load path and filtered output
interface fir_filter_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8
);
    logic              load_sw;
    logic [DATA_W-1:0] data_in;
    logic [COEF_W-1:0] coff_in;
    logic [OUT_W-1:0]  data_out;
    modport master (output load_sw, data_in, coff_in, input data_out);
    modport slave  (input load_sw, data_in, coff_in, output data_out);
endinterface

// File: rtl/fir_tap.sv
// fir_tap: one coefficient and one sample register with shift enables, plus their product
module fir_tap #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_en,
    input  logic                     x_en,
    input  logic [COEF_W-1:0]        coef_d,
    input  logic [DATA_W-1:0]        x_d,
    output logic [COEF_W-1:0]        coef_q,
    output logic [DATA_W-1:0]        x_q,
    output logic [DATA_W+COEF_W-1:0] prod
);
    localparam int P_W = DATA_W + COEF_W;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            coef_q <= '0;
            x_q    <= '0;
        end else begin
            if (coef_en) coef_q <= coef_d;
            if (x_en) x_q <= x_d;
        end
    assign prod = P_W'(coef_q) * P_W'(x_q);
endmodule

// File: rtl/fir_filter.sv
// fir_filter: direct-form FIR with serially loaded coefficients; FIR_ROUND_EN selects round-half-up with saturation
module fir_filter
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8
) (
    input logic       clk,
    input logic       rst,
    fir_filter_if.slave bus
);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int SH    = ACC_W - OUT_W;
    localparam int P_W   = DATA_W + COEF_W;
    mode_e mode;
    logic run;
    logic [COEF_W-1:0] coef_q [TAPS];
    logic [DATA_W-1:0] x_q [TAPS];
    logic [P_W-1:0] prod [TAPS];
    logic [ACC_W-1:0] acc;
    logic [OUT_W-1:0] res;
    logic [OUT_W-1:0] data_q;
    assign mode = mode_e'(bus.load_sw);
    assign run  = mode == RUN;
    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        logic [COEF_W-1:0] coef_d;
        logic [DATA_W-1:0] x_d;
        if (i == 0) begin : g_head
            assign coef_d = bus.coff_in;
            assign x_d    = bus.data_in;
        end else begin : g_body
            assign coef_d = coef_q[i-1];
            assign x_d    = x_q[i-1];
        end
        fir_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_tap (
            .clk(clk), .rst(rst), .coef_en(!run), .x_en(run),
            .coef_d(coef_d), .x_d(x_d),
            .coef_q(coef_q[i]), .x_q(x_q[i]), .prod(prod[i])
        );
    end
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod[k]);
    end
`ifdef FIR_ROUND_EN
    localparam logic [ACC_W:0] HALF = SH == 0 ? '0 : (ACC_W+1)'(1) << (SH == 0 ? 0 : SH - 1);
    logic [ACC_W:0] rnd;
    assign rnd = {1'b0, acc} + HALF;
    // a carry into bit ACC_W means the rounded value no longer fits OUT_W
    assign res = rnd[ACC_W] ? '1 : OUT_W'(rnd[ACC_W-1:0] >> SH);
`else
    assign res = OUT_W'(acc >> SH);
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) data_q <= '0;
        else if (run) data_q <= res;
    assign bus.data_out = data_q;
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed checks of reset, load, impulse, DC, max, mode toggle and async reset
module tb_fir_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    fir_filter_if bus ();
    fir_filter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic load4(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        bus.load_sw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.coff_in = c[i];
            tick();
        end
    endtask
    task automatic test_reset();
        bus.load_sw = 1'b1;
        bus.data_in = 8'd0;
        bus.coff_in = 8'd0;
        tick();
        tick();
        checks++;
        if (bus.data_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: data_out=%0d expected=0", bus.data_out);
        end
        rst = 1'b0;
        bus.data_in = 8'd200;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.data_out !== 8'd0) begin
                errors++;
                $display("FAIL zero_coef_run[%0d]: data_out=%0d expected=0", i, bus.data_out);
            end
        end
    endtask
    task automatic test_load();
        logic [7:0] c [4];
        logic [7:0] exp_c [4];
        c[0] = 8'd124; c[1] = 8'd214; c[2] = 8'd57; c[3] = 8'd33;
        exp_c[0] = 8'd33; exp_c[1] = 8'd57; exp_c[2] = 8'd214; exp_c[3] = 8'd124;
        bus.load_sw = 1'b0;
        bus.data_in = 8'd77;
        for (int i = 0; i < 4; i++) begin
            bus.coff_in = c[i];
            tick();
            checks++;
            if (bus.data_out !== 8'd0) begin
                errors++;
                $display("FAIL load_hold[%0d]: data_out=%0d expected=0", i, bus.data_out);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut.coef_q[k] !== exp_c[k]) begin
                errors++;
                $display("FAIL coef[%0d]: got=%0d expected=%0d", k, dut.coef_q[k], exp_c[k]);
            end
        end
    endtask
    task automatic test_impulse();
        logic [7:0] exp_o [5];
`ifdef FIR_ROUND_EN
        exp_o[0] = 8'd8; exp_o[1] = 8'd14; exp_o[2] = 8'd53; exp_o[3] = 8'd31; exp_o[4] = 8'd0;
`else
        exp_o[0] = 8'd8; exp_o[1] = 8'd14; exp_o[2] = 8'd53; exp_o[3] = 8'd30; exp_o[4] = 8'd0;
`endif
        bus.load_sw = 1'b1;
        bus.data_in = 8'd0;
        for (int i = 0; i < 4; i++) tick();
        bus.data_in = 8'd255;
        tick();
        bus.data_in = 8'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.data_out !== exp_o[i]) begin
                errors++;
                $display("FAIL impulse[%0d]: data_out=%0d expected=%0d", i, bus.data_out, exp_o[i]);
            end
        end
    endtask
    task automatic test_dc();
`ifdef FIR_ROUND_EN
        logic [7:0] e3 = 8'd30, e4 = 8'd42;
`else
        logic [7:0] e3 = 8'd29, e4 = 8'd41;
`endif
        bus.load_sw = 1'b1;
        bus.data_in = 8'd100;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.data_out !== e3) begin
            errors++;
            $display("FAIL dc_partial: data_out=%0d expected=%0d", bus.data_out, e3);
        end
        tick();
        checks++;
        if (bus.data_out !== e4) begin
            errors++;
            $display("FAIL dc_full: data_out=%0d expected=%0d", bus.data_out, e4);
        end
    endtask
    task automatic test_max();
`ifdef FIR_ROUND_EN
        logic [7:0] held = 8'd42;
`else
        logic [7:0] held = 8'd41;
`endif
        load4(8'd255, 8'd255, 8'd255, 8'd255);
        checks++;
        if (bus.data_out !== held) begin
            errors++;
            $display("FAIL max_load_hold: data_out=%0d expected=%0d", bus.data_out, held);
        end
        bus.load_sw = 1'b1;
        bus.data_in = 8'd255;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.data_out !== 8'd254) begin
            errors++;
            $display("FAIL max: data_out=%0d expected=254", bus.data_out);
        end
    endtask
    task automatic test_mode_toggle();
        logic [7:0] d [4];
        d[0] = 8'd250; d[1] = 8'd200; d[2] = 8'd150; d[3] = 8'd100;
        load4(8'd124, 8'd214, 8'd57, 8'd33);
        bus.load_sw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_in = d[i];
            tick();
        end
        checks++;
        if (bus.data_out !== 8'd99) begin
            errors++;
            $display("FAIL toggle_pre: data_out=%0d expected=99", bus.data_out);
        end
        bus.load_sw = 1'b0;
        bus.coff_in = 8'd0;
        tick();
        checks++;
        if (bus.data_out !== 8'd99) begin
            errors++;
            $display("FAIL toggle_hold: data_out=%0d expected=99", bus.data_out);
        end
        bus.load_sw = 1'b1;
        bus.data_in = 8'd50;
        tick();
        checks++;
        if (bus.data_out !== 8'd68) begin
            errors++;
            $display("FAIL toggle_shift0: data_out=%0d expected=68", bus.data_out);
        end
        bus.data_in = 8'd0;
        tick();
        checks++;
        if (bus.data_out !== 8'd53) begin
            errors++;
            $display("FAIL toggle_shift1: data_out=%0d expected=53", bus.data_out);
        end
    endtask
    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: data_out=%0d expected=0", bus.data_out);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut.coef_q[k] !== 8'd0) begin
                errors++;
                $display("FAIL reset_coef[%0d]: got=%0d expected=0", k, dut.coef_q[k]);
            end
        end
        tick();
        rst = 1'b0;
        bus.load_sw = 1'b1;
        bus.data_in = 8'd200;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.data_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_reload_needed: data_out=%0d expected=0", bus.data_out);
        end
    endtask
    initial begin
        test_reset();
        test_load();
        test_impulse();
        test_dc();
        test_max();
        test_mode_toggle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
